// File: rtl/stream_mux_pkg.sv
// Selection-mode encodings shared by the stream multiplexer and its arbiter.
// Any encoding other than MODE_RR and MODE_MANUAL behaves as fixed priority.
package stream_mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_FIXED  = 2'd1;
  localparam logic [1:0] MODE_RR     = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: purely combinational, so a grant is available in the same cycle.
// Round-robin from ptr in MODE_RR, otherwise lowest index wins. No backpressure inside the arbiter.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic [1:0]      mode,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  int   start;
  int   idx;
  logic found;

  // Walk the channels from the start index, wrapping at N rather than 2^SELW.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    start     = (mode == MODE_RR) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N:1 stream mux with manual, fixed-priority and round-robin selection.
// Latency is one cycle. A stalled output word holds, and while it holds every in_ready is low.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [SELW-1:0] grant_idx;
  logic [SELW-1:0] ptr;
  logic            load;
  logic            any_grant;

  // In manual mode only the selected channel may request, so the arbiter's
  // fixed-priority path degenerates to a simple select.
  always_comb begin
    req = in_valid;
    if (mode == MODE_MANUAL) begin
      req = '0;
      if (int'(sel) < N) req[sel] = in_valid[sel];
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .mode      (mode),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load      = !out_valid || out_ready;
  assign any_grant = |grant;
  assign in_ready  = (load && !rst) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any_grant) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*W +: W];
        out_chan  <= grant_idx;
        // Pointer tracks every transfer, whatever the mode, so switching to
        // round-robin continues from the last served channel.
        ptr       <= (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: stimulus pushes the expected words, and a monitor
// pops and compares them whenever an output transfer is observed.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [1:0]      mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;

  logic [W-1:0] dat [N];
  logic [W+SELW-1:0] expq [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [W-1:0] d, input logic [SELW-1:0] c);
    expq.push_back({d, c});
  endtask

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_word", {22'd0, out_data, out_chan}, 32'hFFFF_FFFF);
      end else begin
        logic [W+SELW-1:0] e;
        e = expq.pop_front();
        chk("out_data", 32'(out_data), 32'(e[W+SELW-1:SELW]));
        chk("out_chan", 32'(out_chan), 32'(e[SELW-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) dat[i] = W'(i);
    rst = 1'b1; in_valid = 4'b1111; mode = MODE_RR; sel = '0; out_ready = 1'b1;

    // Reset and idle
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_chan", 32'(out_chan), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0;

    // Round-robin fairness, one word per cycle
    for (int k = 0; k < 6; k++) begin
      expect_word(W'(k % 4), SELW'(k % 4));
      @(negedge clk);
      chk("rr_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
      step();
    end
    in_valid = 4'b0000;
    step();
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 0);
    step();

    // Fixed priority (ptr now 2, must be ignored)
    mode = MODE_FIXED; in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      expect_word(8'h01, 2'd1);
      @(negedge clk);
      chk("fix_in_ready", 32'(in_ready), 32'b0010);
      step();
    end
    in_valid = 4'b1000;
    expect_word(8'h03, 2'd3);
    @(negedge clk);
    chk("fix_in_ready3", 32'(in_ready), 32'b1000);
    step();
    in_valid = 4'b0000;
    step();

    // Manual selection
    mode = MODE_MANUAL; sel = 2'd2; in_valid = 4'b0100; dat[2] = 8'hA5;
    expect_word(8'hA5, 2'd2);
    @(negedge clk);
    chk("man_in_ready", 32'(in_ready), 32'b0100);
    step();
    sel = 2'd1;
    @(negedge clk);
    chk("man_unsel_in_ready", 32'(in_ready), 0);
    step();
    @(negedge clk);
    chk("man_out_valid", 32'(out_valid), 0);

    // Reserved mode acts as fixed priority
    step();
    mode = 2'd3; in_valid = 4'b0110;
    expect_word(8'h01, 2'd1);
    @(negedge clk);
    chk("mode3_in_ready", 32'(in_ready), 32'b0010);
    step();
    in_valid = 4'b0000;
    step();

    // Backpressure: ptr is 2, so channel 2 loads 3C and stalls
    mode = MODE_RR; out_ready = 1'b0; in_valid = 4'b1111; dat[2] = 8'h3C;
    expect_word(8'h3C, 2'd2);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data", 32'(out_data), 32'h3C);
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    expect_word(8'h03, 2'd3);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'b1000);
    step();
    in_valid = 4'b0000;
    step(); step();

    // Reset mid-stall: ptr is 0, channel 1 loads 77 and is then dropped
    out_ready = 1'b0; in_valid = 4'b0010; dat[1] = 8'h77;
    step(); step();
    rst = 1'b1; in_valid = 4'b1111;
    @(negedge clk);
    chk("rst_stall_in_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    expect_word(8'h00, 2'd0);
    @(negedge clk);
    chk("rst_stall_out_valid", 32'(out_valid), 0);
    chk("rst_ptr_in_ready", 32'(in_ready), 32'b0001);
    step();
    in_valid = 4'b0000;
    step(); step();

    chk("queue_empty", 32'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
